route_reserve_allocator: RTL and testbench

ROUTE_RESERVE_ALLOCATOR -- requirements
Module: route_reserve_allocator

---
 rtl/route_reserve_allocator_pkg.sv | 13 +
 rtl/route_reserve_allocator_rr_arbiter.sv | 28 ++
 rtl/route_reserve_allocator.sv | 92 +++++++++
 tb/tb_route_reserve_allocator.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/route_reserve_allocator_pkg.sv
// Shared router types: per-output controller state, port-ID type and the
// default switch radix used by the route reservation logic.
package route_reserve_allocator_pkg;
  localparam int N_PORTS_DEF       = 5;
  localparam int REQUEST_WIDTH_DEF = $clog2(N_PORTS_DEF);

  typedef logic [REQUEST_WIDTH_DEF-1:0] portId_t;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } ctrlState_e;
endpackage

// File: rtl/route_reserve_allocator_rr_arbiter.sv
// N-way round-robin arbiter: searches req starting at ptr and returns a
// one-hot grant (all zero when nothing is requesting).
module rr_arbiter
  import route_reserve_allocator_pkg::*;
#(
  parameter int N = N_PORTS_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant
);
  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/route_reserve_allocator.sv
// Route reservation allocator: one FREE/LOCKED controller per output port,
// each with its own round-robin arbiter over the inputs requesting it.
module route_reserve_allocator
  import route_reserve_allocator_pkg::*;
#(
  parameter int N_PORTS       = N_PORTS_DEF,
  parameter int REQUEST_WIDTH = $clog2(N_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_PORTS-1:0]               reqValid,
  input  logic [N_PORTS*REQUEST_WIDTH-1:0] reqPort,
  input  logic [N_PORTS-1:0]               routeRelieve,
  output logic [N_PORTS-1:0]               reserveStatus,
  output logic [N_PORTS*REQUEST_WIDTH-1:0] outSel,
  output logic [N_PORTS-1:0]               outLocked,
  output logic                             badReq
);
  localparam int W = REQUEST_WIDTH;

  ctrlState_e                    state [N_PORTS];
  logic [N_PORTS-1:0][W-1:0]       ptr, winId;
  logic [N_PORTS-1:0][N_PORTS-1:0] cand, grant;  // [output][input]
  logic [N_PORTS-1:0]              busy, granted;
  logic                            anyBad;

  // An input that already holds an output may not reserve a second one.
  always_comb begin
    busy = '0;
    for (int o = 0; o < N_PORTS; o++)
      if (state[o] == LOCKED) busy[outSel[o*W +: W]] = 1'b1;
  end

  always_comb begin
    cand   = '0;
    anyBad = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (reqValid[i] && int'(reqPort[i*W +: W]) >= N_PORTS) anyBad = 1'b1;
      for (int o = 0; o < N_PORTS; o++)
        cand[o][i] = reqValid[i] && (state[o] == FREE) && !busy[i] &&
                     (int'(reqPort[i*W +: W]) == o);
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : gArb
    rr_arbiter #(.N(N_PORTS), .W(W)) uArb (
      .req  (cand[g]),
      .ptr  (ptr[g]),
      .grant(grant[g])
    );
  end

  always_comb begin
    granted = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      winId[o] = '0;
      for (int i = 0; i < N_PORTS; i++)
        if (grant[o][i]) begin
          winId[o]   = W'(i);
          granted[i] = 1'b1;
        end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < N_PORTS; o++) state[o] <= FREE;
      ptr           <= '0;
      outSel        <= '0;
      reserveStatus <= '0;
      badReq        <= 1'b0;
    end else begin
      reserveStatus <= granted;
      badReq        <= anyBad;
      for (int o = 0; o < N_PORTS; o++) begin
        case (state[o])
          FREE: if (|grant[o]) begin
            state[o]           <= LOCKED;
            outSel[o*W +: W]   <= winId[o];
            ptr[o]             <= (int'(winId[o]) == N_PORTS-1) ? '0 : winId[o] + 1'b1;
          end
          // Release takes effect here; a new grant needs the following edge.
          LOCKED: if (routeRelieve[outSel[o*W +: W]]) state[o] <= FREE;
          default: state[o] <= FREE;
        endcase
      end
    end
  end

  always_comb
    for (int o = 0; o < N_PORTS; o++) outLocked[o] = (state[o] == LOCKED);
endmodule

// File: tb/tb_route_reserve_allocator.sv
// Bench for route_reserve_allocator: directed scenarios plus random traffic
// checked against an owner/pointer model of the reservation rules.
module tb_route_reserve_allocator;
  localparam int N = 5;
  localparam int W = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   reqValid, routeRelieve;
  logic [N*W-1:0] reqPort;
  logic [N-1:0]   reserveStatus, outLocked;
  logic [N*W-1:0] outSel;
  logic           badReq;

  route_reserve_allocator #(.N_PORTS(N), .REQUEST_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqPort(reqPort),
    .routeRelieve(routeRelieve), .reserveStatus(reserveStatus),
    .outSel(outSel), .outLocked(outLocked), .badReq(badReq)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int port [N];
  // model: owner[o] = owning input or -1, rp = pointer, lastSel = held select
  int owner [N], rp [N], lastSel [N];
  logic [N-1:0] eStat;
  logic         eBad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int o = 0; o < N; o++) begin owner[o] = -1; rp[o] = 0; lastSel[o] = 0; end
    eStat = '0; eBad = 1'b0;
  endtask

  function automatic logic [N*W-1:0] expSel();
    logic [N*W-1:0] s;
    for (int o = 0; o < N; o++) s[o*W +: W] = W'(lastSel[o]);
    return s;
  endfunction

  function automatic logic [N-1:0] expLocked();
    logic [N-1:0] l;
    for (int o = 0; o < N; o++) l[o] = (owner[o] >= 0);
    return l;
  endfunction

  task automatic checkAll(input string tag);
    chk({tag, ".reserveStatus"}, 64'(reserveStatus), 64'(eStat));
    chk({tag, ".outLocked"},     64'(outLocked),     64'(expLocked()));
    chk({tag, ".outSel"},        64'(outSel),        64'(expSel()));
    chk({tag, ".badReq"},        64'(badReq),        64'(eBad));
  endtask

  // Apply current inputs for one clock, advance the model, then compare.
  task automatic step(input string tag);
    int  nOwner [N];
    bit  owns [N];
    for (int i = 0; i < N; i++) reqPort[i*W +: W] = W'(port[i]);
    eStat = '0; eBad = 1'b0;
    for (int i = 0; i < N; i++) owns[i] = 1'b0;
    for (int o = 0; o < N; o++) if (owner[o] >= 0) owns[owner[o]] = 1'b1;
    for (int i = 0; i < N; i++) if (reqValid[i] && port[i] >= N) eBad = 1'b1;
    for (int o = 0; o < N; o++) begin
      nOwner[o] = owner[o];
      if (owner[o] < 0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (rp[o] + k) % N;
          if (reqValid[i] && port[i] == o && !owns[i]) begin
            nOwner[o] = i; lastSel[o] = i; rp[o] = (i + 1) % N; eStat[i] = 1'b1;
            break;
          end
        end
      end else if (routeRelieve[owner[o]]) nOwner[o] = -1;
    end
    for (int o = 0; o < N; o++) owner[o] = nOwner[o];
    @(posedge clk); #1;
    checkAll(tag);
  endtask

  task automatic idle();
    reqValid = '0; routeRelieve = '0;
    for (int i = 0; i < N; i++) port[i] = 0;
  endtask

  int order [$];
  int grantCyc [N];
  int expOrder [4] = '{0, 1, 3, 0};

  initial begin
    idle();
    for (int i = 0; i < N; i++) reqPort[i*W +: W] = '0;
    rst = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 checkAll("reset");
    @(negedge clk) rst = 1'b1;
    step("postReset");

    // single request, held three cycles -> exactly one grant
    reqValid[2] = 1'b1; port[2] = 4;
    for (int c = 0; c < 3; c++) step("single");
    idle(); routeRelieve[2] = 1'b1; step("singleRelease");
    idle(); step("singleIdle");

    // contention on output 2 from inputs 0, 1, 3
    for (int j = 0; j < N; j++) grantCyc[j] = -1;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      idle();
      foreach (expOrder[k]) begin reqValid[expOrder[k]] = 1'b1; port[expOrder[k]] = 2; end
      for (int j = 0; j < N; j++)
        if (grantCyc[j] >= 0 && c == grantCyc[j] + 4) begin routeRelieve[j] = 1'b1; grantCyc[j] = -1; end
      step("contend");
      for (int j = 0; j < N; j++) if (reserveStatus[j]) begin order.push_back(j); grantCyc[j] = c; end
    end
    chk("contendCount", 64'(order.size()), 64'd4);
    for (int k = 0; k < 4 && k < order.size(); k++) chk("contendOrder", 64'(order[k]), 64'(expOrder[k]));
    idle(); routeRelieve = '1; step("contendClear");
    idle(); step("contendIdle");

    // release and new request on the same edge
    reqValid[1] = 1'b1; port[1] = 0; step("collGrant");
    idle(); step("collHold");
    idle(); routeRelieve[1] = 1'b1; reqValid[3] = 1'b1; port[3] = 0; step("collRelease");
    chk("collFree", 64'(outLocked[0]), 64'd0);
    idle(); reqValid[3] = 1'b1; port[3] = 0; step("collRegrant");
    chk("collOwner3", 64'(reserveStatus[3]), 64'd1);
    idle(); routeRelieve = '1; step("collClear");

    // non-owner relieve is ignored
    idle(); reqValid[0] = 1'b1; port[0] = 2; step("nonOwnGrant");
    idle(); routeRelieve[4] = 1'b1; step("nonOwnRelieve");
    chk("nonOwnLocked", 64'(outLocked[2]), 64'd1);
    chk("nonOwnSel", 64'(outSel[2*W +: W]), 64'd0);
    idle(); routeRelieve = '1; step("nonOwnClear");

    // out-of-range request ID
    idle(); reqValid[1] = 1'b1; port[1] = 6; step("badReq");
    chk("badPulse", 64'(badReq), 64'd1);
    idle(); step("badAfter");

    // reset in the middle of three reservations
    idle();
    reqValid[0] = 1'b1; port[0] = 3;
    reqValid[2] = 1'b1; port[2] = 1;
    reqValid[4] = 1'b1; port[4] = 4;
    step("midLock");
    idle(); step("midHold");
    #2 rst = 1'b0;
    #1;
    modelReset();
    chk("midRstLocked", 64'(outLocked), 64'd0);
    chk("midRstStatus", 64'(reserveStatus), 64'd0);
    chk("midRstSel", 64'(outSel), 64'd0);
    @(negedge clk) rst = 1'b1;
    step("midNoGrant");
    reqValid[3] = 1'b1; port[3] = 1; reqValid[0] = 1'b1; port[0] = 1;
    step("midPtr0");
    chk("midPtr0Winner", 64'(reserveStatus), 64'b00001);
    idle(); routeRelieve = '1; step("midClear");

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        reqValid[i]     = ($urandom_range(0, 99) < 60);
        port[i]         = ($urandom_range(0, 19) == 0) ? int'($urandom_range(N, 7)) : int'($urandom_range(0, N-1));
        routeRelieve[i] = ($urandom_range(0, 99) < 25);
      end
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
